// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer for a single external 1-bit ALU cell.
// It works on WIDTH-bit operands LSB first, one bit per clock, and collects F and CarryOut back from the cell.
//
// state  | meaning
// IDLE   | waiting for Start; cell outputs held at 0
// RUN    | one operand bit per cycle presented to the cell
// DONE   | one-cycle Done pulse; Start here chains the next operation
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut,
  output logic             AluS1,
  output logic             AluS0,
  output logic             AluA,
  output logic             AluB,
  output logic             AluCarryIn,
  input  logic             AluF,
  input  logic             AluCarryOut
);

  localparam int CntW = $clog2(WIDTH);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state;
  logic [1:0]       opReg;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] resSh;
  logic [WIDTH-1:0] resNext;
  logic             carry;
  logic [CntW-1:0]  bitCnt;
  logic             running;
  logic             accept;
  logic             lastBit;

  assign running = (state == StRun);
  assign accept  = Start && ((state == StIdle) || (state == StDone));
  assign lastBit = (bitCnt == CntW'(WIDTH - 1));
  assign resNext = {AluF, resSh[WIDTH-1:1]};

  assign Busy       = running;
  assign AluS1      = running & opReg[1];
  assign AluS0      = running & opReg[0];
  assign AluA       = running & aSh[0];
  assign AluB       = running & bSh[0];
  assign AluCarryIn = running & carry;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= StIdle;
      opReg    <= '0;
      aSh      <= '0;
      bSh      <= '0;
      resSh    <= '0;
      carry    <= 1'b0;
      bitCnt   <= '0;
      Done     <= 1'b0;
      Result   <= '0;
      CarryOut <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        StRun: begin
          resSh  <= resNext;
          carry  <= AluCarryOut;
          aSh    <= aSh >> 1;
          bSh    <= bSh >> 1;
          bitCnt <= bitCnt + CntW'(1);
          if (lastBit) begin
            state    <= StDone;
            Done     <= 1'b1;
            Result   <= resNext;
            // Logic ops still ripple the cell's adder carry; it is not meaningful for them.
            CarryOut <= opReg[1] & AluCarryOut;
          end
        end
        default: begin
          if (accept) begin
            state  <= StRun;
            opReg  <= Op;
            aSh    <= OpA;
            bSh    <= OpB;
            carry  <= Op[1] & (~Op[0] | CarryIn);
            bitCnt <= '0;
          end else begin
            state <= StIdle;
          end
        end
      endcase
    end
  end

endmodule
